// File: rtl/panda_divider.sv
// RV32M iterative divider: restoring division with one quotient bit per cycle,
// early completion for divide-by-zero and signed overflow, single-pulse write-back.
module panda_divider #(
    parameter int unsigned Width     = 32,
    parameter int unsigned AddrWidth = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [1:0]           op_i,
    input  logic [Width-1:0]     rs1_data_i,
    input  logic [Width-1:0]     rs2_data_i,
    input  logic [AddrWidth-1:0] rd_addr_i,
    input  logic                 flush_i,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic [AddrWidth-1:0] rd_addr_o,
    output logic [Width-1:0]     rd_data_o,
    output logic                 rd_we_o
);

    localparam int unsigned CntWidth = $clog2(Width);
    localparam logic [CntWidth-1:0] LastCnt = CntWidth'(Width - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q;
    logic                  is_rem_q, neg_quot_q, neg_rem_q;
    logic [Width-1:0]      divisor_q, quot_q;
    logic [Width:0]        rem_q;
    logic [AddrWidth-1:0]  addr_q;
    logic [AddrWidth-1:0]  rd_addr_q;
    logic [Width-1:0]      rd_data_q;

    logic                  accept, is_signed, is_rem, div_zero, overflow, special;
    logic [Width-1:0]      abs_a, abs_b, special_res;
    logic [Width:0]        rem_sh, diff, rem_nx;
    logic                  q_bit;
    logic [Width-1:0]      quot_nx, q_fin, r_fin, result;

    assign accept    = (state_q == IDLE) && start_i && !flush_i;
    assign is_signed = ~op_i[0];
    assign is_rem    = op_i[1];
    assign div_zero  = (rs2_data_i == '0);
    assign overflow  = is_signed && (rs1_data_i == {1'b1, {(Width-1){1'b0}}})
                       && (rs2_data_i == '1);
    assign special   = div_zero || overflow;

    assign abs_a = (is_signed && rs1_data_i[Width-1]) ? -rs1_data_i : rs1_data_i;
    assign abs_b = (is_signed && rs2_data_i[Width-1]) ? -rs2_data_i : rs2_data_i;

    // Divide-by-zero: quotient all ones, remainder = dividend.
    // Overflow: quotient = dividend (0x80000000), remainder 0.
    always_comb begin
        special_res = '0;
        if (div_zero) special_res = is_rem ? rs1_data_i : '1;
        else          special_res = is_rem ? '0 : rs1_data_i;
    end

    // One restoring step: shift in next dividend bit, try subtracting divisor.
    assign rem_sh  = {rem_q[Width-1:0], quot_q[Width-1]};
    assign diff    = rem_sh - {1'b0, divisor_q};
    assign q_bit   = ~diff[Width];
    assign rem_nx  = q_bit ? diff : rem_sh;
    assign quot_nx = {quot_q[Width-2:0], q_bit};

    assign q_fin  = neg_quot_q ? -quot_nx : quot_nx;
    assign r_fin  = neg_rem_q ? -rem_nx[Width-1:0] : rem_nx[Width-1:0];
    assign result = is_rem_q ? r_fin : q_fin;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = special ? DONE : CALC;
            CALC: begin
                if (flush_i)              state_d = IDLE;
                else if (cnt_q == LastCnt) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_rem_q   <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            divisor_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            addr_q     <= '0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q      <= '0;
                is_rem_q   <= is_rem;
                neg_quot_q <= is_signed && (rs1_data_i[Width-1] ^ rs2_data_i[Width-1]);
                neg_rem_q  <= is_signed && rs1_data_i[Width-1];
                divisor_q  <= abs_b;
                quot_q     <= abs_a;
                rem_q      <= '0;
                addr_q     <= rd_addr_i;
                if (special) begin
                    rd_data_q <= special_res;
                    rd_addr_q <= rd_addr_i;
                end
            end else if (state_q == CALC && !flush_i) begin
                cnt_q  <= cnt_q + 1'b1;
                quot_q <= quot_nx;
                rem_q  <= rem_nx;
                if (cnt_q == LastCnt) begin
                    rd_data_q <= result;
                    rd_addr_q <= addr_q;
                end
            end
        end
    end

    assign ready_o   = (state_q == IDLE);
    assign busy_o    = (state_q != IDLE);
    assign rd_we_o   = (state_q == DONE) && !flush_i && (addr_q != '0);
    assign rd_addr_o = rd_addr_q;
    assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_panda_divider.sv
// Scoreboard bench for panda_divider: the driver queues expected write-backs,
// a negedge monitor checks data, address and arrival cycle.
module tb_panda_divider;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = '0;
    logic [31:0] rs1_data_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        flush_i = 1'b0;
    logic        ready_o, busy_o, rd_we_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    panda_divider #(.Width(32), .AddrWidth(5)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .op_i(op_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .rd_addr_i(rd_addr_i),
        .flush_i(flush_i), .ready_o(ready_o), .busy_o(busy_o),
        .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .rd_we_o(rd_we_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            OP_DIV:  return sa / sb;
            OP_DIVU: return a / b;
            OP_REM:  return sa % sb;
            default: return a % b;
        endcase
    endfunction

    // Monitor: every write-back must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_ni && rd_we_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_we", {27'd0, rd_addr_o}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", rd_data_o, e.data);
                    check("rd_addr", {27'd0, rd_addr_o}, {27'd0, e.addr});
                    check("latency", cyc, e.due);
                end
            end
        end
    end

    // Present a request for one edge; returns the cycle count just after acceptance.
    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int acc);
        @(negedge clk_i);
        start_i = 1'b1; op_i = op; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_ready(input string name, input int lat);
        int n = 0;
        do begin
            @(posedge clk_i);
            #1;
            n++;
        end while (!ready_o && n < 100);
        check(name, n, lat);
    endtask

    task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] expv, input int lat);
        int acc;
        exp_t e;
        drive(op, a, b, rd, acc);
        if (rd != 5'd0) begin
            e.data = expv; e.addr = rd; e.due = acc + lat - 1;
            exp_q.push_back(e);
        end
        wait_ready("ready_return", lat);
    endtask

    initial begin
        int acc;
        logic [31:0] a, b;
        logic [1:0]  op;
        logic [4:0]  rd;

        repeat (3) @(posedge clk_i);
        #1;
        check("reset_ready", {31'd0, ready_o}, 32'd1);
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        check("reset_we", {31'd0, rd_we_o}, 32'd0);
        check("reset_data", rd_data_o, 32'd0);
        check("reset_addr", {27'd0, rd_addr_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        run(OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 33);
        run(OP_REMU, 32'd100, 32'd7, 5'd5, 32'd2, 33);
        run(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 33);
        run(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 33);
        run(OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd8, 32'hFFFF_FFFD, 33);
        run(OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd9, 32'd1, 33);
        run(OP_DIVU, 32'h1234_5678, 32'd0, 5'd10, 32'hFFFF_FFFF, 1);
        run(OP_REMU, 32'h1234_5678, 32'd0, 5'd11, 32'h1234_5678, 1);
        run(OP_DIV, 32'hFFFF_FF00, 32'd0, 5'd12, 32'hFFFF_FFFF, 1);
        run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1);
        run(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0, 1);
        run(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 33);
        run(OP_DIVU, 32'd9, 32'd3, 5'd0, 32'd3, 33);

        // Flush while idle must block acceptance.
        @(negedge clk_i);
        start_i = 1'b1; flush_i = 1'b1; op_i = OP_DIVU; rs1_data_i = 32'd9;
        rs2_data_i = 32'd3; rd_addr_i = 5'd3;
        @(posedge clk_i);
        #1;
        start_i = 1'b0; flush_i = 1'b0;
        check("idle_flush_ready", {31'd0, ready_o}, 32'd1);

        // Flush in the tenth CALC cycle: no write-back, ready on the next edge.
        drive(OP_DIVU, 32'd1000, 32'd3, 5'd4, acc);
        repeat (9) @(posedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        check("flush_ready", {31'd0, ready_o}, 32'd1);
        check("flush_busy", {31'd0, busy_o}, 32'd0);
        repeat (40) @(posedge clk_i);

        // Reset in the twentieth CALC cycle: abandoned, outputs cleared.
        drive(OP_DIVU, 32'd1000, 32'd3, 5'd4, acc);
        repeat (19) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_data", rd_data_o, 32'd0);
        check("rst_addr", {27'd0, rd_addr_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (40) @(posedge clk_i);

        for (int i = 0; i < 1000; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 15));
                3:       b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
            rd = 5'($urandom_range(0, 31));
            run(op, a, b, rd, ref_model(op, a, b),
                (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33);
        end

        repeat (3) @(posedge clk_i);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/panda_divider.md
PANDA_DIVIDER -- requirements
Module: panda_divider

Interface
REQ-001 SHALL have parameter Width, default 32: operand/result width; only 32 is supported (RV32M).
REQ-002 SHALL have parameter AddrWidth, default 5: register address width matching the 32-entry register file.
REQ-003 SHALL have port clk_i  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_ni  input  1: reset; synchronous, active-low.
REQ-005 SHALL have port start_i  input  1: request valid; accepted only when ready_o=1.
REQ-006 SHALL have port op_i  input  2: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 SHALL have port rs1_data_i  input  Width: dividend, read from the register file.
REQ-008 SHALL have port rs2_data_i  input  Width: divisor, read from the register file.
REQ-009 SHALL have port rd_addr_i  input  AddrWidth: destination register.
REQ-010 SHALL have port flush_i  input  1: abort in-flight operation.
REQ-011 SHALL have port ready_o  output  1: idle, can accept.
REQ-012 SHALL have port busy_o  output  1: operation in flight (CALC or DONE).
REQ-013 SHALL have port rd_addr_o  output  AddrWidth: write-back address to register file.
REQ-014 SHALL have port rd_data_o  output  Width: write-back data.
REQ-015 SHALL have port rd_we_o  output  1: write-back enable, single-cycle pulse.

Function
REQ-016 SHALL implement FSM states IDLE, CALC, DONE; ready_o=1 only in IDLE; busy_o=1 in CALC and DONE.
REQ-017 SHALL accept on a rising edge with start_i=1, ready_o=1, flush_i=0; latch op_i, operands, rd_addr_i; start_i otherwise ignored.
REQ-018 SHALL, for divisor 0, go IDLE->DONE: quotient 0xFFFFFFFF (DIV and DIVU), remainder = dividend.
REQ-019 SHALL, for DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF, go IDLE->DONE: quotient 0x80000000, remainder 0.
REQ-020 SHALL otherwise go IDLE->CALC and run restoring division on magnitudes (unsigned for DIVU/REMU, absolute values for DIV/REM), one quotient bit per cycle, exactly 32 CALC cycles via a 5-bit counter, then CALC->DONE.
REQ-021 SHALL apply sign correction in signed ops: quotient negated when operand signs differ; remainder takes dividend sign; results truncated to Width bits.
REQ-022 SHALL in DONE drive rd_data_o (quotient for DIV/DIVU, remainder for REM/REMU), rd_addr_o = latched address, rd_we_o=1 for exactly that cycle, then DONE->IDLE.
REQ-023 SHALL keep latency from accept edge to rd_we_o: 1 cycle for special cases (REQ-018/019), 33 cycles otherwise.
REQ-024 SHALL suppress rd_we_o (hold 0) when latched rd address is 0; FSM timing unchanged.
REQ-025 SHALL on flush_i=1 in CALC or DONE return to IDLE next edge with rd_we_o=0 that cycle; flush_i in IDLE blocks acceptance (flush wins over start).
REQ-026 SHALL hold rd_data_o and rd_addr_o at last written values outside DONE; rd_we_o=0 outside DONE.
REQ-027 SHALL not accept a new request in DONE; earliest back-to-back accept is the edge after DONE (in IDLE).

Reset
REQ-028 SHALL on rst_ni=0 at a rising edge enter IDLE, clearing counter, rd_we_o=0, rd_data_o=0, rd_addr_o=0, busy_o=0, ready_o=1.
REQ-029 SHALL on reset mid-operation (CALC or DONE) abandon the operation with no write-back; reset overrides start_i and flush_i.

Verification
REQ-030 SHALL cover DIVU 100/7, rd=5 -> rd_we_o one cycle, 33 cycles after accept, rd_data_o=14, rd_addr_o=5; REMU same -> 2.
REQ-031 SHALL cover DIV 0xFFFFFFF9 (-7)/2 -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); DIV 7/-2 -> 0xFFFFFFFD.
REQ-032 SHALL cover DIVU 0x12345678/0 -> 0xFFFFFFFF after 1 cycle; REMU -> 0x12345678 after 1 cycle.
REQ-033 SHALL cover DIV 0x80000000/0xFFFFFFFF -> 0x80000000 after 1 cycle; REM -> 0.
REQ-034 SHALL cover flush_i at cycle 10 of CALC -> no rd_we_o, ready_o=1 next cycle; rst_ni=0 at cycle 20 -> same, outputs zero.
REQ-035 SHALL cover rd_addr_i=0 with DIVU 9/3 -> rd_we_o stays 0, ready_o returns after 33 cycles; plus 1000 random ops checked against a reference model.
